mipi_sensor_init_seq: RTL and testbench



---
 rtl/mipi_init_pkg.sv | 33 +++
 rtl/mipi_sensor_init_seq_timer.sv | 37 +++
 rtl/mipi_sensor_init_seq.sv | 205 ++++++++++++++++++++
 tb/tb_mipi_sensor_init_seq.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mipi_init_pkg.sv
// Shared encodings for the MIPI sensor init sequencer: ROM entry layout,
// opcodes and FSM state encoding.
package mipi_init_pkg;

  // ROM entry layout: [25:24] opcode, [23:8] register address, [7:0] data
  localparam int ROM_W   = 26;
  localparam int OP_LSB  = 24;
  localparam int REG_LSB = 8;
  localparam int DAT_LSB = 0;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_DELAY = 2'b01;
  localparam logic [1:0] OP_END   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST_HOLD,
    S_PWR_WAIT,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT_RSP,
    S_DELAY,
    S_NEXT,
    S_DONE,
    S_FAIL
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mipi_sensor_init_seq_timer.sv
// Shared cycle counter for the init sequencer. Restarts from zero whenever
// the sequencer changes state, so each state measures its own dwell time.
// Saturates instead of wrapping so a long stall can never alias a target.
module mipi_sensor_init_seq_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear on state change, otherwise count up and hold at max
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mipi_sensor_init_seq.sv
// Power-up configuration sequencer for the MIPI camera sensor: pulses the
// sensor reset, waits for power-up, then walks the register-init ROM issuing
// IIC writes and timed delays, with retry on NACK/timeout.
module mipi_sensor_init_seq
  import mipi_init_pkg::*;
#(
  parameter int unsigned ROM_AW       = 8,
  parameter logic [6:0]  DEV_ADDR     = 7'h36,
  parameter int unsigned RST_HOLD_CYC = 500000,
  parameter int unsigned PWR_WAIT_CYC = 1000000,
  parameter int unsigned DELAY_UNIT   = 50000,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned RSP_TIMEOUT  = 100000
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [ROM_W-1:0]  rom_data,
  output logic              sensor_rst,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [6:0]        cmd_dev_addr,
  output logic [15:0]       cmd_reg_addr,
  output logic [7:0]        cmd_wdata,
  input  logic              rsp_valid,
  input  logic              rsp_nack,
  output logic              busy,
  output logic              init_done,
  output logic              init_err,
  output logic [ROM_AW-1:0] err_index
);

  // Counter must cover the longest dwell, including a 255-unit delay entry
  localparam int unsigned CNT_MAX = max_u(max_u(RST_HOLD_CYC, PWR_WAIT_CYC),
                                          max_u(255 * DELAY_UNIT, RSP_TIMEOUT));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned RTY_W   = $clog2(MAX_RETRY + 2);

  localparam logic [CNT_W-1:0]  RST_LAST  = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0]  PWR_LAST  = CNT_W'(PWR_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0]  RSP_LAST  = CNT_W'(RSP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  DLY_UNIT  = CNT_W'(DELAY_UNIT);
  localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RETRY);
  localparam logic [ROM_AW-1:0] ADDR_LAST = '1;

  state_e            state_q, state_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic [ROM_AW-1:0] err_index_q, err_index_d;
  logic [6:0]        dev_q, dev_d;
  logic [15:0]       reg_q, reg_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        dly_q, dly_d;
  logic [RTY_W-1:0]  rty_q, rty_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [CNT_W-1:0]  cnt;
  logic              cnt_clr;
  logic [CNT_W-1:0]  dly_tgt;
  logic              dly_done;
  logic [RTY_W-1:0]  rty_inc;
  logic [1:0]        op;

  assign cnt_clr  = (state_d != state_q);
  assign dly_tgt  = CNT_W'(dly_q) * DLY_UNIT;
  assign dly_done = (dly_tgt == '0) || (cnt == dly_tgt - CNT_W'(1));
  assign rty_inc  = rty_q + RTY_W'(1);
  assign op       = rom_data[OP_LSB +: 2];

  mipi_sensor_init_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i (clk_50m),
    .rst_i (rst),
    .clr_i (cnt_clr),
    .cnt_o (cnt)
  );

  // Next-state and register-update logic for the sequencer
  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    err_index_d = err_index_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    dly_d       = dly_q;
    rty_d       = rty_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d     = 1'b0;
          err_d      = 1'b0;
          rom_addr_d = '0;
          rty_d      = '0;
          busy_d     = 1'b1;
          state_d    = S_RST_HOLD;
        end
      end
      S_RST_HOLD: if (cnt == RST_LAST) state_d = S_PWR_WAIT;
      S_PWR_WAIT: if (cnt == PWR_LAST) state_d = S_FETCH;
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_WRITE: begin
            dev_d   = DEV_ADDR;
            reg_d   = rom_data[REG_LSB +: 16];
            wdata_d = rom_data[DAT_LSB +: 8];
            state_d = S_ISSUE;
          end
          OP_DELAY: begin
            dly_d   = rom_data[DAT_LSB +: 8];
            state_d = S_DELAY;
          end
          OP_END:   state_d = S_DONE;
          default: begin
            err_index_d = rom_addr_q;
            state_d     = S_FAIL;
          end
        endcase
      end
      S_ISSUE: if (cmd_ready) state_d = S_WAIT_RSP;
      S_WAIT_RSP: begin
        if (rsp_valid && !rsp_nack) begin
          state_d = S_NEXT;
        end else if (rsp_valid || cnt == RSP_LAST) begin
          rty_d = rty_inc;
          if (rty_inc <= RTY_MAX) begin
            state_d = S_ISSUE;
          end else begin
            err_index_d = rom_addr_q;
            state_d     = S_FAIL;
          end
        end
      end
      S_DELAY: if (dly_done) state_d = S_NEXT;
      S_NEXT: begin
        rty_d = '0;
        if (rom_addr_q == ADDR_LAST) begin
          state_d = S_DONE;
        end else begin
          rom_addr_d = rom_addr_q + ROM_AW'(1);
          state_d    = S_FETCH;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_FAIL: begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset returns every output to zero
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      err_index_q <= '0;
      dev_q       <= '0;
      reg_q       <= '0;
      wdata_q     <= '0;
      dly_q       <= '0;
      rty_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      err_index_q <= err_index_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      dly_q       <= dly_d;
      rty_q       <= rty_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign sensor_rst   = (state_q == S_RST_HOLD);
  assign cmd_valid    = (state_q == S_ISSUE);
  assign cmd_dev_addr = dev_q;
  assign cmd_reg_addr = reg_q;
  assign cmd_wdata    = wdata_q;
  assign busy         = busy_q;
  assign init_done    = done_q;
  assign init_err     = err_q;
  assign err_index    = err_index_q;

endmodule

// File: tb/tb_mipi_sensor_init_seq.sv
// Bench for the MIPI sensor init sequencer: a synchronous ROM model, an IIC
// write-master model with scripted ACK/NACK/silence, and a command scoreboard.
`timescale 1ns/1ps
module tb_mipi_sensor_init_seq;

  localparam int AW       = 4;
  localparam int K_ACK    = 0;
  localparam int K_NACK   = 1;
  localparam int K_SILENT = 2;

  logic          clk_50m = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [25:0]   rom_data = '0;
  logic          sensor_rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [6:0]    cmd_dev_addr;
  logic [15:0]   cmd_reg_addr;
  logic [7:0]    cmd_wdata;
  logic          rsp_valid;
  logic          rsp_nack;
  logic          busy;
  logic          init_done;
  logic          init_err;
  logic [AW-1:0] err_index;

  logic [25:0]   rom [16];
  logic [23:0]   exp_q [$];
  int            rsp_plan [$];
  int            checks = 0;
  int            errors = 0;
  int            ready_delay = 0;
  int            rsp_lat = 2;
  int            ncmd = 0;
  int            sr_hi = 0;
  int            sr_pulses = 0;
  int            first_lat = -1;

  mipi_sensor_init_seq #(
    .ROM_AW       (AW),
    .DEV_ADDR     (7'h36),
    .RST_HOLD_CYC (10),
    .PWR_WAIT_CYC (20),
    .DELAY_UNIT   (4),
    .MAX_RETRY    (3),
    .RSP_TIMEOUT  (30)
  ) dut (
    .clk_50m      (clk_50m),
    .rst          (rst),
    .start        (start),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .sensor_rst   (sensor_rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_dev_addr (cmd_dev_addr),
    .cmd_reg_addr (cmd_reg_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_nack     (rsp_nack),
    .busy         (busy),
    .init_done    (init_done),
    .init_err     (init_err),
    .err_index    (err_index)
  );

  always #10 clk_50m = ~clk_50m;

  // Synchronous ROM: data valid one cycle after the address
  always @(posedge clk_50m) rom_data <= rom[rom_addr];

  function automatic logic [25:0] ent(input logic [1:0] op, input logic [15:0] ra,
                                      input logic [7:0] d);
    return {op, ra, d};
  endfunction

  // IIC master model, scoreboard and sensor_rst monitor; all at the falling edge
  initial begin : iic_model
    bit          pend;
    int          pend_kind;
    int          wait_n;
    int          rdy_n;
    bit          sr_prev;
    bit          lat_armed;
    int          t_cnt;
    logic [23:0] exp_v;
    pend = 0; pend_kind = K_ACK; wait_n = 0; rdy_n = 0;
    sr_prev = 0; lat_armed = 0; t_cnt = 0;
    cmd_ready = 0; rsp_valid = 0; rsp_nack = 0;
    forever begin
      @(negedge clk_50m);
      rsp_valid = 0;
      rsp_nack  = 0;
      if (pend) begin
        if (wait_n == 0) begin
          pend = 0;
          if (pend_kind != K_SILENT) begin
            rsp_valid = 1;
            rsp_nack  = (pend_kind == K_NACK);
          end
        end else begin
          wait_n--;
        end
      end
      if (sensor_rst) begin
        sr_hi++;
        if (!sr_prev) sr_pulses++;
      end
      if (sr_prev && !sensor_rst) begin
        t_cnt = 0;
        lat_armed = 1;
      end else if (lat_armed) begin
        t_cnt++;
      end
      if (lat_armed && cmd_valid) begin
        first_lat = t_cnt;
        lat_armed = 0;
      end
      sr_prev = sensor_rst;
      if (!cmd_valid) begin
        cmd_ready = 0;
        rdy_n = 0;
      end else if (rdy_n < ready_delay) begin
        cmd_ready = 0;
        rdy_n++;
      end else begin
        cmd_ready = 1;
      end
      if (cmd_valid) begin
        if (exp_q.size() != 0) begin
          exp_v = exp_q[0];
          checks++;
          if ({cmd_dev_addr, cmd_reg_addr, cmd_wdata} !== {7'h36, exp_v}) begin
            errors++;
            $display("FAIL cmd_fields got dev=%h reg=%h data=%h want dev=36 reg=%h data=%h",
                     cmd_dev_addr, cmd_reg_addr, cmd_wdata, exp_v[23:8], exp_v[7:0]);
          end
        end else if (cmd_ready) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cmd got reg=%h data=%h want no command",
                   cmd_reg_addr, cmd_wdata);
        end
        if (cmd_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          ncmd++;
          rdy_n  = 0;
          pend   = 1;
          wait_n = rsp_lat;
          if (rsp_plan.size() != 0) pend_kind = rsp_plan.pop_front();
          else pend_kind = K_ACK;
        end
      end
    end
  end

  task automatic prep();
    for (int i = 0; i < 16; i++) rom[i] = ent(2'b10, 16'h0000, 8'h00);
    exp_q.delete();
    rsp_plan.delete();
    ready_delay = 0;
    rsp_lat     = 2;
    ncmd        = 0;
    sr_hi       = 0;
    sr_pulses   = 0;
    first_lat   = -1;
  endtask

  task automatic pulse_start();
    @(negedge clk_50m);
    start = 1;
    @(negedge clk_50m);
    start = 0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_50m);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_ncmd(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_50m);
      if (ncmd >= n) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk_50m);
    checks++;
    if ({busy, init_done, init_err, cmd_valid, sensor_rst} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000",
               {busy, init_done, init_err, cmd_valid, sensor_rst});
    end
    checks++;
    if ({rom_addr, err_index, cmd_dev_addr, cmd_reg_addr, cmd_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_data got addr=%h idx=%h dev=%h reg=%h data=%h want all 0",
               rom_addr, err_index, cmd_dev_addr, cmd_reg_addr, cmd_wdata);
    end
    rst = 0;
    repeat (5) @(negedge clk_50m);
    checks++;
    if ({busy, sensor_rst} !== 2'b00) begin
      errors++;
      $display("FAIL idle_no_start got busy=%b srst=%b want 0 0", busy, sensor_rst);
    end
  endtask

  task automatic test_single_write();
    bit ok;
    prep();
    rom[0] = ent(2'b00, 16'h0100, 8'h00);
    exp_q.push_back({16'h0100, 8'h00});
    pulse_start();
    wait_idle(2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_done_wait got busy=%b want 0", busy); end
    checks++;
    if (sr_hi !== 10) begin errors++; $display("FAIL srst_width got %0d want 10", sr_hi); end
    checks++;
    if (first_lat !== 22) begin errors++; $display("FAIL pwr_to_cmd got %0d want 22", first_lat); end
    checks++;
    if (ncmd !== 1) begin errors++; $display("FAIL single_ncmd got %0d want 1", ncmd); end
    checks++;
    if ({init_done, init_err, busy} !== 3'b100) begin
      errors++;
      $display("FAIL single_status got done/err/busy=%b want 100", {init_done, init_err, busy});
    end
  endtask

  task automatic test_delay();
    bit ok;
    prep();
    rom[0] = ent(2'b01, 16'h0000, 8'd3);
    rom[1] = ent(2'b00, 16'h3000, 8'h5A);
    exp_q.push_back({16'h3000, 8'h5A});
    pulse_start();
    wait_idle(2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL delay_done_wait got busy=%b want 0", busy); end
    checks++;
    if (first_lat !== 37) begin errors++; $display("FAIL delay_latency got %0d want 37", first_lat); end
    checks++;
    if (ncmd !== 1 || init_done !== 1'b1) begin
      errors++;
      $display("FAIL delay_result got ncmd=%0d done=%b want 1 1", ncmd, init_done);
    end
  endtask

  task automatic test_retry_ok();
    bit ok;
    prep();
    rom[0] = ent(2'b00, 16'h0100, 8'h01);
    rom[1] = ent(2'b00, 16'h3500, 8'h22);
    exp_q.push_back({16'h0100, 8'h01});
    for (int i = 0; i < 3; i++) exp_q.push_back({16'h3500, 8'h22});
    rsp_plan = '{K_ACK, K_NACK, K_NACK, K_ACK};
    pulse_start();
    wait_idle(3000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL retry_ok_wait got busy=%b want 0", busy); end
    checks++;
    if (ncmd !== 4) begin errors++; $display("FAIL retry_ok_ncmd got %0d want 4", ncmd); end
    checks++;
    if ({init_done, init_err} !== 2'b10) begin
      errors++;
      $display("FAIL retry_ok_status got done/err=%b want 10", {init_done, init_err});
    end
  endtask

  task automatic test_retry_fail();
    bit ok;
    prep();
    for (int i = 0; i < 4; i++) rom[i] = ent(2'b00, 16'h0100 + 16'(i), 8'h10 + 8'(i));
    exp_q.push_back({16'h0100, 8'h10});
    exp_q.push_back({16'h0101, 8'h11});
    for (int i = 0; i < 4; i++) exp_q.push_back({16'h0102, 8'h12});
    rsp_plan = '{K_ACK, K_ACK, K_NACK, K_NACK, K_NACK, K_NACK};
    pulse_start();
    wait_idle(3000, ok);
    repeat (10) @(negedge clk_50m);
    checks++;
    if (!ok) begin errors++; $display("FAIL retry_fail_wait got busy=%b want 0", busy); end
    checks++;
    if (ncmd !== 6) begin errors++; $display("FAIL retry_fail_ncmd got %0d want 6", ncmd); end
    checks++;
    if ({init_done, init_err} !== 2'b01 || err_index !== 4'd2) begin
      errors++;
      $display("FAIL retry_fail_status got done/err=%b idx=%0d want 01 2",
               {init_done, init_err}, err_index);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    prep();
    rom[0] = ent(2'b00, 16'h4000, 8'hA5);
    for (int i = 0; i < 4; i++) exp_q.push_back({16'h4000, 8'hA5});
    rsp_plan = '{K_SILENT, K_SILENT, K_SILENT, K_SILENT};
    ready_delay = 50;
    pulse_start();
    wait_idle(3000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL timeout_wait got busy=%b want 0", busy); end
    checks++;
    if (ncmd !== 4) begin errors++; $display("FAIL timeout_ncmd got %0d want 4", ncmd); end
    checks++;
    if ({init_done, init_err} !== 2'b01 || err_index !== 4'd0) begin
      errors++;
      $display("FAIL timeout_status got done/err=%b idx=%0d want 01 0",
               {init_done, init_err}, err_index);
    end
  endtask

  task automatic test_no_wrap();
    bit ok;
    prep();
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        rom[i] = ent(2'b01, 16'h0000, 8'd0);
      end else begin
        rom[i] = ent(2'b00, 16'h1000 + 16'(i), 8'(i));
        exp_q.push_back({16'h1000 + 16'(i), 8'(i)});
      end
    end
    pulse_start();
    wait_idle(3000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL nowrap_wait got busy=%b want 0", busy); end
    checks++;
    if (ncmd !== 15) begin errors++; $display("FAIL nowrap_ncmd got %0d want 15", ncmd); end
    checks++;
    if (init_done !== 1'b1 || rom_addr !== 4'hF) begin
      errors++;
      $display("FAIL nowrap_end got done=%b addr=%h want 1 f", init_done, rom_addr);
    end
  endtask

  task automatic test_illegal();
    bit ok;
    prep();
    rom[0] = ent(2'b00, 16'h0200, 8'h01);
    rom[1] = ent(2'b11, 16'h0201, 8'h02);
    rom[2] = ent(2'b00, 16'h0202, 8'h03);
    exp_q.push_back({16'h0200, 8'h01});
    pulse_start();
    wait_idle(2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL illegal_wait got busy=%b want 0", busy); end
    checks++;
    if ({init_done, init_err} !== 2'b01 || err_index !== 4'd1 || ncmd !== 1) begin
      errors++;
      $display("FAIL illegal_status got done/err=%b idx=%0d ncmd=%0d want 01 1 1",
               {init_done, init_err}, err_index, ncmd);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    prep();
    rom[0] = ent(2'b00, 16'h0300, 8'h31);
    rom[1] = ent(2'b00, 16'h0301, 8'h32);
    exp_q.push_back({16'h0300, 8'h31});
    exp_q.push_back({16'h0301, 8'h32});
    pulse_start();
    wait_ncmd(1, 2000, ok);
    rsp_lat = 15;
    wait_ncmd(2, 2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_reach_wait got ncmd=%0d want 2", ncmd); end
    @(negedge clk_50m);
    rst = 1;
    @(negedge clk_50m);
    rst = 0;
    checks++;
    if ({busy, init_done, init_err, cmd_valid, sensor_rst} !== 5'b0 ||
        {rom_addr, err_index, cmd_dev_addr, cmd_reg_addr, cmd_wdata} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outs got ctrl=%b addr=%h idx=%h reg=%h want all 0",
               {busy, init_done, init_err, cmd_valid, sensor_rst}, rom_addr, err_index,
               cmd_reg_addr);
    end
    repeat (25) @(negedge clk_50m);
    checks++;
    if ({busy, init_done, init_err, cmd_valid} !== 4'b0) begin
      errors++;
      $display("FAIL late_rsp_ignored got busy/done/err/valid=%b want 0000",
               {busy, init_done, init_err, cmd_valid});
    end
    prep();
    rom[0] = ent(2'b00, 16'h0300, 8'h31);
    rom[1] = ent(2'b00, 16'h0301, 8'h32);
    exp_q.push_back({16'h0300, 8'h31});
    exp_q.push_back({16'h0301, 8'h32});
    pulse_start();
    repeat (4) @(negedge clk_50m);
    pulse_start();
    wait_idle(2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL restart_wait got busy=%b want 0", busy); end
    checks++;
    if (sr_hi !== 10 || sr_pulses !== 1) begin
      errors++;
      $display("FAIL restart_srst got width=%0d pulses=%0d want 10 1", sr_hi, sr_pulses);
    end
    checks++;
    if (ncmd !== 2 || init_done !== 1'b1) begin
      errors++;
      $display("FAIL restart_result got ncmd=%0d done=%b want 2 1", ncmd, init_done);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = '0;
    test_reset();
    test_single_write();
    test_delay();
    test_retry_ok();
    test_retry_fail();
    test_timeout();
    test_no_wrap();
    test_illegal();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d entries want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
